// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch block:
//               FSM state encoding, the canonical NOP, the PC increment and a
//               word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;  // nothing requested, waiting for credit
  localparam fetch_state_t ST_REQ  = 2'd1;  // icache_req asserted
  localparam fetch_state_t ST_WAIT = 2'd2;  // request accepted, response wanted
  localparam fetch_state_t ST_DROP = 2'd3;  // request accepted, response unwanted

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PC_INC   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Small synchronous FIFO holding {pc, instruction} pairs
//               between the I-cache response and the IF/ID register.
//               clear wins over push and pop in the same cycle.
// Ports       : clk, rst_n (async, active-low)
//               push/din   - write one entry
//               pop/dout   - dout shows the head entry; pop removes it
//               clear      - empty the FIFO
//               count      - current occupancy (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // Guard against over/underflow even though the controller never asks.
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Issues one I-cache read at a
//               time, buffers returned words with their PC in fetch_buf and
//               drives the IF/ID register. Honours stall and redirect.
// Ports       : clk, rst_n (async, active-low)
//               icache_req/addr/ready  - request handshake
//               icache_valid/rdata     - response
//               stall_i, redirect_i, redirect_pc - pipeline control
//               id_valid/id_inst/id_pc - IF/ID register
//               perf_stall_cyc/perf_flush_cnt/perf_bubble_cnt
//                                      - only with FETCH_PERF_CNT_EN
// Config      : define FETCH_PERF_CNT_EN to add saturating perf counters
//               (parameter CNT_W sets their width).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
`ifdef FETCH_PERF_CNT_EN
  , parameter int        CNT_W     = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic        icache_valid,
  input  logic [31:0] icache_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_stall_cyc
  , output logic [CNT_W-1:0] perf_flush_cnt
  , output logic [CNT_W-1:0] perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic [31:0]  id_pc_q, id_pc_d;

  logic [CW-1:0] buf_count;
  logic [63:0]   buf_dout, buf_din;
  logic          buf_push, buf_pop;
  logic [CW:0]   cnt_after_push;
  logic          can_issue, can_issue_after_push, load_slot;

  always_comb begin
    // In IDLE nothing is outstanding, so credit is simply free buffer space.
    can_issue      = buf_count < CW'(BUF_DEPTH);
    load_slot      = !redirect_i && !stall_i;
    buf_pop        = load_slot && (buf_count != '0);
    cnt_after_push = {1'b0, buf_count} + (CW+1)'(1) - {{CW{1'b0}}, buf_pop};
    can_issue_after_push = cnt_after_push < (CW+1)'(BUF_DEPTH);
    // pc has already advanced past the accepted address while in WAIT.
    buf_din  = {pc_q - PC_INC, icache_rdata};
    buf_push = 1'b0;
    state_d  = state_q;
    pc_d     = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (redirect_i || can_issue) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (icache_ready) begin
          pc_d    = pc_q + PC_INC;
          state_d = redirect_i ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (icache_valid) begin
          if (redirect_i) begin
            state_d = ST_REQ;
          end else begin
            buf_push = 1'b1;
            state_d  = can_issue_after_push ? ST_REQ : ST_IDLE;
          end
        end else if (redirect_i) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (icache_valid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_i) pc_d = word_align(redirect_pc);

    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    if (redirect_i) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (!stall_i) begin
      if (buf_count != '0) begin
        id_valid_d = 1'b1;
        id_inst_d  = buf_dout[31:0];
        id_pc_d    = buf_dout[63:32];
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (64)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (redirect_i),
    .din   (buf_din),
    .dout  (buf_dout),
    .count (buf_count)
  );

  assign icache_req  = (state_q == ST_REQ);
  assign icache_addr = pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cyc_d  = stall_cyc_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_i && (stall_cyc_q != '1))                   stall_cyc_d  = stall_cyc_q + CNT_W'(1);
    if (redirect_i && (flush_cnt_q != '1))                flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    if (load_slot && (buf_count == '0) && (bubble_cnt_q != '1))
                                                          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cyc_q  <= stall_cyc_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cyc  = stall_cyc_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Scoreboard bench for fetch_ctrl. A cache model answers
//               requests with a fixed address->word map; every accepted,
//               non-flushed request pushes its expected {pc, inst} into a
//               queue which an independent monitor pops as the IF/ID register
//               loads new instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req, icache_ready, icache_valid;
  logic [31:0] icache_addr, icache_rdata;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst, id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_ready (icache_ready),
    .icache_valid (icache_valid),
    .icache_rdata (icache_rdata),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .id_pc        (id_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cyc  (perf_stall_cyc)
    , .perf_flush_cnt  (perf_flush_cnt)
    , .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Cache / fetch-order model
  logic [31:0] exp_addr;
  bit          outstanding;
  logic [31:0] out_addr;
  int          delay;
  bit          chk_req_next, exp_req_next;
  int          cyc, first_req_cyc, first_val_cyc;
  int          exp_stall, exp_flush, exp_bubble;

  // Stimulus knobs
  int          ready_pct, max_delay, stall_pct, redir_pct;
  bit          stall_force, redir_force;
  logic [31:0] redir_force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ({a[15:0], a[31:16]} ^ 32'h1234_5678);
  endfunction

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return 32'($urandom_range(1023));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus, decided on the falling edge.
  task automatic step();
    logic accept;
    @(negedge clk);
    cyc++;
    if (first_req_cyc < 0 && icache_req) first_req_cyc = cyc;
    if (first_val_cyc < 0 && id_valid)   first_val_cyc = cyc;
    if (chk_req_next) chk("req_after_redirect", 32'(icache_req), 32'(exp_req_next));
    if (outstanding)  chk("no_req_while_outstanding", 32'(icache_req), 32'h0);

    icache_valid = 1'b0;
    icache_rdata = $urandom;
    if (outstanding) begin
      if (delay == 0) begin
        icache_valid = 1'b1;
        icache_rdata = mem_word(out_addr);
      end else begin
        delay--;
      end
    end
    icache_ready = ($urandom_range(99) < ready_pct);
    stall_i      = stall_force || ($urandom_range(99) < stall_pct);
    redirect_i   = redir_force || ($urandom_range(99) < redir_pct);
    redirect_pc  = redir_force ? redir_force_pc : rand_pc();
    redir_force  = 1'b0;

    accept = icache_req && icache_ready;
    if (accept) chk("fetch_addr", icache_addr, exp_addr);
    if (icache_valid) outstanding = 1'b0;
    if (accept) begin
      outstanding = 1'b1;
      out_addr    = exp_addr;
      delay       = $urandom_range(max_delay);
      if (!redirect_i) begin
        exp_t e;
        e.pc   = exp_addr;
        e.inst = mem_word(exp_addr);
        sb_q.push_back(e);
      end
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect_i) begin
      sb_q.delete();
      exp_addr     = redirect_pc & ~32'h3;
      exp_req_next = !outstanding;
    end
    chk_req_next = redirect_i;
    if (stall_i)    exp_stall++;
    if (redirect_i) exp_flush++;
  endtask

  task automatic do_reset(input bit late_valid);
    @(negedge clk);
    rst_n        = 1'b0;
    icache_ready = 1'b0;
    icache_valid = late_valid;
    icache_rdata = 32'hDEAD_BEEF;
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(icache_req), 32'h0);
    chk("rst_addr", icache_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cyc, 32'h0);
    chk("rst_perf_flush", perf_flush_cnt, 32'h0);
    chk("rst_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
    rst_n = 1'b1;  // late response lands in the first post-reset cycle
    sb_q.delete();
    exp_addr      = RESET_PC;
    outstanding   = 1'b0;
    delay         = 0;
    chk_req_next  = 1'b0;
    cyc           = 0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    exp_stall     = 0;
    exp_flush     = 0;
    exp_bubble    = 0;
  endtask

  // Monitor: judges the IF/ID register after every rising edge.
  initial begin
    logic        p_stall, p_redir;
    logic        h_valid;
    logic [31:0] h_inst, h_pc;
    exp_t        e;
    h_valid = 1'b0;
    h_inst  = NOP_INST;
    h_pc    = 32'h0;
    forever begin
      @(posedge clk);
      p_stall = stall_i;
      p_redir = redirect_i;
      #1;
      if (!rst_n) begin
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_inst", id_inst, NOP_INST);
        chk("rst_id_pc", id_pc, 32'h0);
      end else if (p_redir) begin
        chk("flush_valid", 32'(id_valid), 32'h0);
        chk("flush_inst", id_inst, NOP_INST);
      end else if (p_stall) begin
        chk("stall_hold_valid", 32'(id_valid), 32'(h_valid));
        chk("stall_hold_inst", id_inst, h_inst);
        chk("stall_hold_pc", id_pc, h_pc);
      end else if (id_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got pc %h, expected no instruction", id_pc);
        end else begin
          e = sb_q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_inst", id_inst, e.inst);
        end
      end else begin
        chk("bubble_inst", id_inst, NOP_INST);
        exp_bubble++;
      end
      h_valid = id_valid;
      h_inst  = id_inst;
      h_pc    = id_pc;
    end
  end

  initial begin
    rst_n        = 1'b1;
    icache_ready = 1'b0;
    icache_valid = 1'b0;
    icache_rdata = 32'h0;
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    redirect_pc  = 32'h0;
    stall_force  = 1'b0;
    redir_force  = 1'b0;
    #1 rst_n = 1'b0;

    // Latency from first request to first valid IF/ID, ideal cache.
    ready_pct = 100; max_delay = 0; stall_pct = 0; redir_pct = 0;
    do_reset(1'b0);
    repeat (8) step();
    chk("first_fetch_latency", 32'(first_val_cyc - first_req_cyc), 32'd3);

    // Long stall fills the buffer and halts requests; nothing lost after.
    stall_force = 1'b1;
    repeat (6) step();
    chk("req_low_when_full", 32'(icache_req), 32'h0);
    stall_force = 1'b0;
    repeat (8) step();

    // Redirect while a response is still owed (response must be dropped).
    max_delay = 2;
    for (int i = 0; i < 20 && !(outstanding && delay > 0); i++) step();
    redir_force = 1'b1; redir_force_pc = 32'h0000_0100;
    step();
    repeat (10) step();

    // Redirect in the same cycle the response arrives.
    for (int i = 0; i < 20 && !(outstanding && delay == 0); i++) step();
    redir_force = 1'b1; redir_force_pc = 32'h0000_0100;
    step();
    repeat (10) step();

    // Unaligned redirect target, then wrap past the top of memory.
    max_delay = 0;
    redir_force = 1'b1; redir_force_pc = 32'h0000_0103;
    step();
    repeat (8) step();
    redir_force = 1'b1; redir_force_pc = 32'hFFFF_FFF8;
    step();
    repeat (14) step();

    // Randomised traffic.
    ready_pct = 70; max_delay = 3; stall_pct = 25; redir_pct = 4;
    repeat (3000) step();

    // Reset mid-transaction with a late response arriving afterwards.
    ready_pct = 100; max_delay = 3; stall_pct = 0; redir_pct = 0;
    for (int i = 0; i < 20 && !outstanding; i++) step();
    max_delay = 0;
    do_reset(1'b1);
    repeat (10) step();
    chk("post_reset_latency", 32'(first_val_cyc - first_req_cyc), 32'd3);

    // Drain: no new accepts, every accepted instruction must appear.
    ready_pct = 0;
    repeat (20) step();
    chk("all_delivered", 32'(sb_q.size()), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cyc, 32'(exp_stall));
    chk("perf_flush", perf_flush_cnt, 32'(exp_flush));
    chk("perf_bubble", perf_bubble_cnt, 32'(exp_bubble));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
